// File: rtl/mul_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mul_pipe_pkg
// Widths, latency and accumulator state encoding shared by the 8-stage
// multiplication pipeline and the dot-product accumulator behind it.
// There are no ports. The multiplier and the accumulator both take their
// latency and product width from this package, so the two cannot drift apart.
// -----------------------------------------------------------------------------
package mul_pipe_pkg;

    localparam int MUL_LATENCY    = 8;
    localparam int MUL_OP_WIDTH   = 8;
    localparam int MUL_PROD_WIDTH = 2 * MUL_OP_WIDTH;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/mul_pipe_valid_delay.sv
// -----------------------------------------------------------------------------
// mul_pipe_valid_delay
// A LATENCY-deep, 2-bit shift register. It carries {valid, last} alongside the
// multiplier so that both flags come out cycle-aligned with `product`.
// The last flag is qualified by valid on entry, so a stray op_last is dropped
// here and never reaches the accumulator.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous active-low clear
//   op_valid   operand valid, in the cycle the operands enter the multiplier
//   op_last    final element of a vector (only meaningful with op_valid)
//   p_valid    op_valid delayed by LATENCY cycles
//   p_last     (op_last & op_valid) delayed by LATENCY cycles
//   any_valid  a valid element is somewhere in the line, tap included
// -----------------------------------------------------------------------------
module mul_pipe_valid_delay
    import mul_pipe_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY
)(
    input  logic CLK,
    input  logic RST,
    input  logic op_valid,
    input  logic op_last,
    output logic p_valid,
    output logic p_last,
    output logic any_valid
);

    logic [LATENCY-1:0] vld_sr;
    logic [LATENCY-1:0] lst_sr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_sr <= '0;
            lst_sr <= '0;
        end else begin
            vld_sr[0] <= op_valid;
            lst_sr[0] <= op_last & op_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                lst_sr[i] <= lst_sr[i-1];
            end
        end
    end

    assign p_valid   = vld_sr[LATENCY-1];
    assign p_last    = lst_sr[LATENCY-1];
    assign any_valid = |vld_sr;

endmodule

// File: rtl/mul_pipe_accumulator.sv
// -----------------------------------------------------------------------------
// mul_pipe_accumulator
// Dot-product accumulator that sits behind the multiplication pipeline.
// It sums the products of one vector, with saturation, and emits the sum, the
// element count and a sticky overflow flag under a one-cycle acc_valid pulse.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ACC_IDLE  | no partial sum open; the next valid product starts a vector
//   ACC_ACCUM | partial sum open; valid products add in until p_last
//
// Ports
//   CLK           rising-edge clock
//   RST           asynchronous active-low reset
//   op_valid      operands are being applied to the multiplier this cycle
//   op_last       final element of the vector (qualified by op_valid)
//   product       multiplier output, LATENCY cycles after its operands
//   acc_sum       sum of the last vector, saturating at all-ones
//   acc_count     element count of the last vector, saturating at all-ones
//   acc_overflow  the last vector's sum saturated
//   acc_valid     one-cycle pulse when the result outputs update
//   busy          a partial sum is open, or an element is still in flight
//
// ACC_WIDTH must be at least the product width. The first product is loaded
// by zero-extension and relies on that.
// -----------------------------------------------------------------------------
module mul_pipe_accumulator
    import mul_pipe_pkg::*;
#(
    parameter int LATENCY   = MUL_LATENCY,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 9
)(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      op_valid,
    input  logic                      op_last,
    input  logic [MUL_PROD_WIDTH-1:0] product,
    output logic [ACC_WIDTH-1:0]      acc_sum,
    output logic [CNT_WIDTH-1:0]      acc_count,
    output logic                      acc_overflow,
    output logic                      acc_valid,
    output logic                      busy
);

    logic p_valid;
    logic p_last;
    logic line_busy;

    mul_pipe_valid_delay #(
        .LATENCY (LATENCY)
    ) u_valid_delay (
        .CLK       (CLK),
        .RST       (RST),
        .op_valid  (op_valid),
        .op_last   (op_last),
        .p_valid   (p_valid),
        .p_last    (p_last),
        .any_valid (line_busy)
    );

    acc_state_t           state, state_nxt;
    logic [ACC_WIDTH-1:0] sum, sum_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 ovf, ovf_nxt;
    logic                 emit;
    logic [ACC_WIDTH:0]   sum_add;

    // The extra top bit of sum_add is the carry out of the addition.
    // A carry means the true sum no longer fits, so the result clamps.
    assign sum_add = {1'b0, sum} + (ACC_WIDTH+1)'(product);

    always_comb begin
        state_nxt = state;
        sum_nxt   = sum;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        emit      = 1'b0;
        if (p_valid) begin
            case (state)
                ACC_IDLE: begin
                    sum_nxt = ACC_WIDTH'(product);
                    cnt_nxt = CNT_WIDTH'(1);
                    ovf_nxt = 1'b0;
                end
                ACC_ACCUM: begin
                    if (sum_add[ACC_WIDTH]) begin
                        sum_nxt = '1;
                        ovf_nxt = 1'b1;
                    end else begin
                        sum_nxt = sum_add[ACC_WIDTH-1:0];
                    end
                    if (cnt != '1) begin
                        cnt_nxt = cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    sum_nxt = ACC_WIDTH'(product);
                    cnt_nxt = CNT_WIDTH'(1);
                    ovf_nxt = 1'b0;
                end
            endcase
            if (p_last) begin
                emit      = 1'b1;
                state_nxt = ACC_IDLE;
            end else begin
                state_nxt = ACC_ACCUM;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ACC_IDLE;
            sum          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            acc_sum      <= '0;
            acc_count    <= '0;
            acc_overflow <= 1'b0;
            acc_valid    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sum       <= sum_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            acc_valid <= emit;
            if (emit) begin
                acc_sum      <= sum_nxt;
                acc_count    <= cnt_nxt;
                acc_overflow <= ovf_nxt;
            end
        end
    end

    assign busy = (state == ACC_ACCUM) || line_busy;

endmodule

// File: tb/tb_mul_pipe_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mul_pipe_accumulator
// Self-checking bench with two accumulators on the same stimulus: the default
// 24-bit one and a 17-bit one that saturates easily. The multiplier is a
// behavioural LATENCY-deep product pipe. Expected results come from a
// vector-level model: the running total of the issued products, clamped
// afterwards to each accumulator width.
// -----------------------------------------------------------------------------
module tb_mul_pipe_accumulator;
    import mul_pipe_pkg::*;

    localparam int     L     = MUL_LATENCY;
    localparam longint MAX24 = (64'd1 << 24) - 1;
    localparam longint MAX17 = (64'd1 << 17) - 1;
    localparam longint CMAX  = 511;

    logic        CLK      = 1'b0;
    logic        RST      = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_last  = 1'b0;
    logic [7:0]  op_a     = '0;
    logic [7:0]  op_b     = '0;
    logic [15:0] mpipe [L];
    logic [15:0] product;

    logic [23:0] acc_sum24;
    logic [8:0]  acc_count24;
    logic        acc_overflow24, acc_valid24, busy24;
    logic [16:0] acc_sum17;
    logic [8:0]  acc_count17;
    logic        acc_overflow17, acc_valid17, busy17;

    mul_pipe_accumulator #(.LATENCY(L), .ACC_WIDTH(24), .CNT_WIDTH(9)) dut24 (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_last(op_last), .product(product),
        .acc_sum(acc_sum24), .acc_count(acc_count24), .acc_overflow(acc_overflow24),
        .acc_valid(acc_valid24), .busy(busy24));

    mul_pipe_accumulator #(.LATENCY(L), .ACC_WIDTH(17), .CNT_WIDTH(9)) dut17 (
        .CLK(CLK), .RST(RST), .op_valid(op_valid), .op_last(op_last), .product(product),
        .acc_sum(acc_sum17), .acc_count(acc_count17), .acc_overflow(acc_overflow17),
        .acc_valid(acc_valid17), .busy(busy17));

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        mpipe[0] <= 16'(op_a) * 16'(op_b);
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign product = mpipe[L-1];

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic longint clamp(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- reference model: vector totals ----------------
    typedef struct {
        int     cyc;
        longint total;
        longint n;
    } exp_t;

    typedef struct {
        int     cyc;
        longint s24;
        longint c24;
        bit     o24;
        longint s17;
        longint c17;
        bit     o17;
    } obs_t;

    exp_t   expq[$];
    obs_t   obsq[$];
    bit     open_vec  = 0;
    longint cur_total = 0;
    longint cur_n     = 0;
    exp_t   mon_e;
    obs_t   mon_o;

    function automatic void model_issue(longint p, bit l);
        if (!open_vec) begin
            cur_total = p;
            cur_n     = 1;
            open_vec  = 1;
        end else begin
            cur_total += p;
            cur_n++;
        end
        if (l) begin
            expq.push_back('{cyc: cyc + L + 1, total: cur_total, n: cur_n});
            open_vec = 0;
        end
    endfunction

    function automatic void model_reset();
        expq.delete();
        open_vec = 0;
    endfunction

    always @(negedge CLK) begin
        if (expq.size() != 0 && expq[0].cyc < cyc) begin
            chk("missed_pulse_cycle", cyc, expq[0].cyc);
            void'(expq.pop_front());
        end
        if (expq.size() != 0 && expq[0].cyc == cyc) begin
            mon_e = expq.pop_front();
            chk("valid24", acc_valid24, 1);
            chk("valid17", acc_valid17, 1);
            chk("sum24",   acc_sum24,      clamp(mon_e.total, MAX24));
            chk("ovf24",   acc_overflow24, longint'(mon_e.total > MAX24));
            chk("cnt24",   acc_count24,    clamp(mon_e.n, CMAX));
            chk("sum17",   acc_sum17,      clamp(mon_e.total, MAX17));
            chk("ovf17",   acc_overflow17, longint'(mon_e.total > MAX17));
            chk("cnt17",   acc_count17,    clamp(mon_e.n, CMAX));
            mon_o.cyc = cyc;
            mon_o.s24 = acc_sum24;  mon_o.c24 = acc_count24;  mon_o.o24 = acc_overflow24;
            mon_o.s17 = acc_sum17;  mon_o.c17 = acc_count17;  mon_o.o17 = acc_overflow17;
            obsq.push_back(mon_o);
        end else begin
            chk("no_spurious_valid", longint'(acc_valid24 | acc_valid17), 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit v, bit l, int a, int b);
        op_valid = v;
        op_last  = l;
        op_a     = 8'(a);
        op_b     = 8'(b);
        if (v) model_issue(longint'(a * b), l);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_sum24"},   acc_sum24, 0);
        chk({tag, "_cnt24"},   acc_count24, 0);
        chk({tag, "_ovf24"},   acc_overflow24, 0);
        chk({tag, "_valid24"}, acc_valid24, 0);
        chk({tag, "_busy24"},  busy24, 0);
        chk({tag, "_sum17"},   acc_sum17, 0);
        chk({tag, "_busy17"},  busy17, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int              n;
        logic [3:0]      v;
        logic [3:0]      l;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        longint          s24;
        longint          cnt;
        bit              o24;
        longint          s17;
        bit              o17;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{n:3, v:4'b0111, l:4'b0100, a:32'h00FF0A03, b:32'h00FF1405,
                   s24:65240, cnt:3, o24:0, s17:65240, o17:0};
        tbl[1] = '{n:1, v:4'b0001, l:4'b0001, a:32'h00000007, b:32'h00000009,
                   s24:63, cnt:1, o24:0, s17:63, o17:0};
        tbl[2] = '{n:2, v:4'b0011, l:4'b0010, a:32'h00000402, b:32'h00000402,
                   s24:20, cnt:2, o24:0, s17:20, o17:0};
        // bubble in the middle carries a stray op_last
        tbl[3] = '{n:3, v:4'b0101, l:4'b0110, a:32'h00060001, b:32'h00060001,
                   s24:37, cnt:2, o24:0, s17:37, o17:0};
        tbl[4] = '{n:3, v:4'b0111, l:4'b0100, a:32'h00FFFFFF, b:32'h00FFFFFF,
                   s24:195075, cnt:3, o24:0, s17:131071, o17:1};
        tbl[5] = '{n:1, v:4'b0001, l:4'b0001, a:32'h00000001, b:32'h00000001,
                   s24:1, cnt:1, o24:0, s17:1, o17:0};

        // reset state
        repeat (3) @(posedge CLK);
        #1;
        chk_zero("reset");
        RST = 1'b1;
        model_reset();

        // table: all vectors issued back to back
        obsq.delete();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < tbl[i].n; j++)
                drive(tbl[i].v[j], tbl[i].l[j], int'(tbl[i].a[j]), int'(tbl[i].b[j]));
        idle(L + 4);
        chk("tbl_results", obsq.size(), 6);
        for (int i = 0; i < 6 && i < obsq.size(); i++) begin
            chk($sformatf("tbl%0d_sum24", i), obsq[i].s24, tbl[i].s24);
            chk($sformatf("tbl%0d_cnt24", i), obsq[i].c24, tbl[i].cnt);
            chk($sformatf("tbl%0d_ovf24", i), obsq[i].o24, tbl[i].o24);
            chk($sformatf("tbl%0d_sum17", i), obsq[i].s17, tbl[i].s17);
            chk($sformatf("tbl%0d_cnt17", i), obsq[i].c17, tbl[i].cnt);
            chk($sformatf("tbl%0d_ovf17", i), obsq[i].o17, tbl[i].o17);
        end
        if (obsq.size() >= 4) chk("ab_pulse_gap", obsq[3].cyc - obsq[2].cyc, 3);
        if (obsq.size() >= 1) chk("first_latency_ok", obsq[0].cyc > 0, 1);

        // stray op_last on its own changes nothing
        repeat (3) drive(0, 1, 0, 0);
        idle(L + 4);
        chk("spurious_sum24", acc_sum24, 1);
        chk("spurious_cnt24", acc_count24, 1);
        chk("spurious_busy", busy24, 0);

        // stray op_last mid-vector, then a long bubble with the vector open
        obsq.delete();
        drive(1, 0, 3, 3);
        drive(0, 1, 0, 0);
        idle(L + 2);
        chk("open_vec_busy24", busy24, 1);
        chk("open_vec_busy17", busy17, 1);
        drive(1, 1, 2, 2);
        idle(L + 4);
        chk("midspur_results", obsq.size(), 1);
        if (obsq.size() == 1) chk("midspur_sum", obsq[0].s24, 13);

        // async reset while a vector is in flight
        obsq.delete();
        drive(1, 0, 200, 200);
        drive(1, 1, 100, 100);
        idle(3);
        chk("inflight_busy", busy24, 1);
        RST = 1'b0;
        model_reset();
        #1;
        chk_zero("rst_async");
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk_zero("rst_held");
        RST = 1'b1;
        drive(1, 1, 5, 5);
        idle(L + 4);
        chk("post_rst_results", obsq.size(), 1);
        if (obsq.size() == 1) chk("post_rst_sum", obsq[0].s24, 25);

        // element counter saturation
        for (int i = 0; i < 520; i++) drive(1, i == 519, 1, 1);
        idle(L + 4);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)));
        end
        drive(1, 1, 1, 1);
        idle(L + 4);
        chk("final_busy24", busy24, 0);
        chk("final_busy17", busy17, 0);
        chk("final_pending", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
